// File: rtl/conv_exec_unit.sv
// conv_exec_unit: scalar ALU ops plus direct/Winograd/pruned-Winograd F(2,3) conv on one shared multiplier; CONV_PERF_CNT_EN adds perf counters
module conv_exec_unit #(
  parameter int LANE_WIDTH = 8,
  parameter int ACC_WIDTH = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  ALUControl,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] Result,
  output logic        out_valid,
  input  logic        out_ready
`ifdef CONV_PERF_CNT_EN
  ,
  output logic [31:0] perf_mul_cnt,
  output logic [31:0] perf_skip_cnt
`endif
);
  localparam logic [1:0] IDLE = 2'd0, MUL = 2'd1, FINAL = 2'd2, DONE = 2'd3;
  typedef logic signed [10:0] w_t;
  function automatic w_t lane(input logic [31:0] x, input int i);
    return w_t'($signed(x[i*LANE_WIDTH +: LANE_WIDTH]));
  endfunction
  function automatic logic [43:0] factors(input logic [31:0] b);
    w_t g0, g1, g2;
    g0 = lane(b, 0);
    g1 = lane(b, 1);
    g2 = lane(b, 2);
    return {g2, g0 - g1 + g2, g0 + g1 + g2, g0};
  endfunction
  function automatic logic [15:0] sat(input logic signed [ACC_WIDTH-1:0] v);
    return v > 32767 ? 16'h7fff : v < -32768 ? 16'h8000 : v[15:0];
  endfunction
  logic [1:0] state, k, dsel, gsel;
  logic [2:0] op_q, cnt, n, pop, n_in;
  logic [31:0] a_q, scal;
  logic [23:0] b_q;
  logic [3:0] mask, nzi, mask_in;
  logic [43:0] fi, fq;
  logic direct, is_scalar;
  w_t mx, my;
  logic signed [21:0] prod;
  logic signed [ACC_WIDTH-1:0] acc0, acc1, p, add0, add1, y0, y1;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign fi = factors(SrcB);
  assign fq = factors({8'd0, b_q});
  assign nzi = {|fi[43:33], |fi[32:22], |fi[21:11], |fi[10:0]};
  assign pop = 3'(nzi[0]) + 3'(nzi[1]) + 3'(nzi[2]) + 3'(nzi[3]);
  assign mask_in = ALUControl == 3'b101 ? nzi : 4'hf;
  assign n_in = ALUControl == 3'b111 ? 3'd6 : ALUControl == 3'b110 ? 3'd4 : pop;
  assign is_scalar = !ALUControl[2] || ALUControl == 3'b100;
  assign scal = ALUControl == 3'b001 ? SrcA - SrcB :
                ALUControl == 3'b010 ? SrcA & SrcB :
                ALUControl == 3'b011 ? SrcA | SrcB : SrcA + SrcB;
  // Direct conv walks (d0g0,d1g1,d2g2) then (d1g0,d2g1,d3g2); Winograd picks the lowest pending Mk
  assign direct = op_q == 3'b111;
  assign dsel = cnt < 3'd3 ? cnt[1:0] : 2'(cnt - 3'd2);
  assign gsel = cnt < 3'd3 ? cnt[1:0] : 2'(cnt - 3'd3);
  assign k = mask[0] ? 2'd0 : mask[1] ? 2'd1 : mask[2] ? 2'd2 : 2'd3;
  assign mx = direct ? lane(a_q, int'(dsel)) :
              k == 2'd0 ? w_t'((lane(a_q, 0) - lane(a_q, 2)) <<< 1) :
              k == 2'd1 ? lane(a_q, 1) + lane(a_q, 2) :
              k == 2'd2 ? lane(a_q, 2) - lane(a_q, 1) :
              w_t'((lane(a_q, 1) - lane(a_q, 3)) <<< 1);
  assign my = direct ? lane({8'd0, b_q}, int'(gsel)) : w_t'(fq[11*k +: 11]);
  assign prod = 22'(mx) * 22'(my);
  assign p = ACC_WIDTH'(prod);
  assign add0 = direct ? (cnt < 3'd3 ? p : '0) : (k == 2'd3 ? '0 : p);
  assign add1 = direct ? (cnt < 3'd3 ? '0 : p) : k == 2'd0 ? '0 : k == 2'd1 ? p : -p;
  // Winograd terms carry a factor of 2 so both sums are even and the shift is exact
  assign y0 = direct ? acc0 : acc0 >>> 1;
  assign y1 = direct ? acc1 : acc1 >>> 1;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      mask <= '0;
      cnt <= '0;
      n <= '0;
      acc0 <= '0;
      acc1 <= '0;
      Result <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op_q <= ALUControl;
          a_q <= SrcA;
          b_q <= SrcB[23:0];
          mask <= mask_in;
          n <= n_in;
          cnt <= '0;
          acc0 <= '0;
          acc1 <= '0;
          if (is_scalar) Result <= scal;
          state <= is_scalar ? DONE : n_in == 3'd0 ? FINAL : MUL;
        end
        MUL: begin
          acc0 <= acc0 + add0;
          acc1 <= acc1 + add1;
          mask <= mask & ~(4'b1 << k);
          cnt <= cnt == n ? cnt : cnt + 3'd1;
          state <= cnt + 3'd1 >= n ? FINAL : MUL;
        end
        FINAL: begin
          Result <= {sat(y1), sat(y0)};
          state <= DONE;
        end
        default: if (out_ready) state <= IDLE;
      endcase
    end
  end
`ifdef CONV_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_mul_cnt <= '0;
      perf_skip_cnt <= '0;
    end else begin
      perf_mul_cnt <= perf_mul_cnt + (state == MUL ? 32'd1 : 32'd0);
      perf_skip_cnt <= perf_skip_cnt + (state == IDLE && in_valid && ALUControl == 3'b101 ? 32'(3'd4 - pop) : 32'd0);
    end
  end
`endif
endmodule
